// File: rtl/matrix_mem_responder_if.sv
// Accelerator request bus plus secondary host port of the matrix scratchpad.
// The master modport is the initiator side. The slave modport is the memory side.
interface matrix_mem_responder_if #(
  parameter int DATA_BW = 32,
  parameter int ADDR_BW = 10
);
  logic [1:0]         mem_operation;
  logic [31:0]        addr_i;
  logic [DATA_BW-1:0] data_i;
  logic [DATA_BW-1:0] data_o;
  logic               mem_opdone;
  logic               host_en;
  logic               host_we;
  logic [ADDR_BW-1:0] host_addr;
  logic [DATA_BW-1:0] host_wdata;
  logic [DATA_BW-1:0] host_rdata;
  logic               host_ready;

  modport master (
    output mem_operation, addr_i, data_i, host_en, host_we, host_addr, host_wdata,
    input  data_o, mem_opdone, host_rdata, host_ready
  );

  modport slave (
    input  mem_operation, addr_i, data_i, host_en, host_we, host_addr, host_wdata,
    output data_o, mem_opdone, host_rdata, host_ready
  );
endinterface

// File: rtl/matrix_mem_responder.sv
// Word-addressed scratchpad for the matrix engine. Accelerator requests complete with a fixed latency.
// A host port gets access only when the accelerator side is idle.
module matrix_mem_responder #(
  parameter int DATA_BW       = 32,
  parameter int ADDR_BW       = 10,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  matrix_mem_responder_if.slave         bus,
  output logic                          err_o
);
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BUSY    = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;
  localparam logic [1:0] ST_RECOVER = 2'd3;

  localparam logic [1:0] OP_NONE    = 2'b00;
  localparam logic [1:0] OP_READ    = 2'b01;
  localparam logic [1:0] OP_ILLEGAL = 2'b10;
  localparam logic [1:0] OP_WRITE   = 2'b11;

  localparam logic [3:0] RD_CNT = 4'(READ_LATENCY - 1);
  localparam logic [3:0] WR_CNT = 4'(WRITE_LATENCY - 1);

  logic [DATA_BW-1:0] mem [0:(2**ADDR_BW)-1];

  logic [1:0]         state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               is_read_q, is_read_d;
  logic               oor_q, oor_d;
  logic [ADDR_BW-1:0] addr_q, addr_d;
  logic [DATA_BW-1:0] data_q, data_d;
  logic [DATA_BW-1:0] rdata_q, rdata_d;
  logic               err_q, err_d;

  logic               acc_req, in_range, acc_wr_en, host_wr_en, enter_done;
  logic               rd_is_read, rd_oor;
  logic [ADDR_BW-1:0] rd_addr;

  assign acc_req    = !reset && (state_q == ST_IDLE) &&
                      (bus.mem_operation == OP_READ || bus.mem_operation == OP_WRITE);
  assign in_range   = ~|bus.addr_i[31:ADDR_BW];
  assign acc_wr_en  = acc_req && (bus.mem_operation == OP_WRITE) && in_range;
  assign bus.host_ready = !reset && bus.host_en && (state_q == ST_IDLE) &&
                          (bus.mem_operation == OP_NONE);
  assign host_wr_en = bus.host_ready && bus.host_we;

  // With a latency of 1 the read goes straight from IDLE to DONE, so it reads the live request.
  assign rd_is_read = (state_q == ST_IDLE) ? (bus.mem_operation == OP_READ) : is_read_q;
  assign rd_addr    = (state_q == ST_IDLE) ? bus.addr_i[ADDR_BW-1:0] : addr_q;
  assign rd_oor     = (state_q == ST_IDLE) ? !in_range : oor_q;

  // NOTE: every variable gets a default before the case, so no latch can be inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_read_d  = is_read_q;
    oor_d      = oor_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    enter_done = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (acc_req) begin
          is_read_d = (bus.mem_operation == OP_READ);
          addr_d    = bus.addr_i[ADDR_BW-1:0];
          oor_d     = !in_range;
          cnt_d     = is_read_d ? RD_CNT : WR_CNT;
          if (!in_range) err_d = 1'b1;
          if (cnt_d == 4'd0) begin
            state_d    = ST_DONE;
            enter_done = 1'b1;
          end else begin
            state_d = ST_BUSY;
          end
        end else if (bus.mem_operation == OP_ILLEGAL) begin
          err_d = 1'b1;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d    = ST_DONE;
          enter_done = 1'b1;
        end
      end
      ST_DONE:    state_d = ST_RECOVER;
      ST_RECOVER: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    if (enter_done && rd_is_read)
      data_d = rd_oor ? '0 : mem[rd_addr];
    if (bus.host_ready && !bus.host_we)
      rdata_d = mem[bus.host_addr];
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      is_read_q <= 1'b0;
      oor_q     <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_read_q <= is_read_d;
      oor_q     <= oor_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  // NOTE: storage has no reset; contents survive reset and map onto plain RAM.
  always_ff @(posedge clk) begin
    if (acc_wr_en)
      mem[bus.addr_i[ADDR_BW-1:0]] <= bus.data_i;
    else if (host_wr_en)
      mem[bus.host_addr] <= bus.host_wdata;
  end

  assign bus.data_o     = data_q;
  assign bus.mem_opdone = (state_q == ST_DONE);
  assign bus.host_rdata = rdata_q;
  assign err_o          = err_q;
endmodule

// File: tb/tb_matrix_mem_responder.sv
// Randomized self-checking bench for matrix_mem_responder against a word-array reference model.
module tb_matrix_mem_responder;
  localparam int DATA_BW = 32;
  localparam int ADDR_BW = 10;
  localparam int RD_LAT  = 2;
  localparam int WR_LAT  = 1;
  localparam int DEPTH   = 2**ADDR_BW;

  logic clk = 1'b0;
  logic reset;
  logic err_o;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic err_exp = 1'b0;
  logic [DATA_BW-1:0] model [0:DEPTH-1];

  matrix_mem_responder_if #(.DATA_BW(DATA_BW), .ADDR_BW(ADDR_BW)) bus ();

  matrix_mem_responder #(
    .DATA_BW(DATA_BW), .ADDR_BW(ADDR_BW),
    .READ_LATENCY(RD_LAT), .WRITE_LATENCY(WR_LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .err_o (err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic acc_op(input logic [1:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input string tag);
    int   edges;
    int   lat;
    logic ok;
    logic [DATA_BW-1:0] exp;
    lat = (op == 2'b01) ? RD_LAT : WR_LAT;
    ok  = (addr < DEPTH);
    @(negedge clk);
    bus.mem_operation = op;
    bus.addr_i        = addr;
    bus.data_i        = wdata;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    bus.mem_operation = 2'b00;
    while (!bus.mem_opdone && edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check({tag, "_lat"}, 64'(edges), 64'(lat));
    if (!ok) err_exp = 1'b1;
    if (op == 2'b11) begin
      if (ok) model[addr[ADDR_BW-1:0]] = wdata;
    end else begin
      exp = ok ? model[addr[ADDR_BW-1:0]] : '0;
      check({tag, "_data"}, 64'(bus.data_o), 64'(exp));
    end
    @(posedge clk);
    @(negedge clk);
    check({tag, "_pulse"}, 64'(bus.mem_opdone), 64'd0);
    @(posedge clk);
  endtask

  task automatic host_access(input logic we, input logic [ADDR_BW-1:0] addr,
                             input logic [DATA_BW-1:0] wdata, input string tag);
    int waitc = 0;
    @(negedge clk);
    bus.host_en    = 1'b1;
    bus.host_we    = we;
    bus.host_addr  = addr;
    bus.host_wdata = wdata;
    #1;
    while (!bus.host_ready && waitc < 20) begin
      @(negedge clk);
      #1;
      waitc++;
    end
    check({tag, "_rdy"}, 64'(bus.host_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    bus.host_en = 1'b0;
    if (we) model[addr] = wdata;
    else    check({tag, "_rd"}, 64'(bus.host_rdata), 64'(model[addr]));
  endtask

  initial begin
    int w;
    int c0;
    int prev;
    int bad;
    logic [31:0] a;
    logic [31:0] d;

    reset = 1'b1;
    bus.mem_operation = 2'b00;
    bus.addr_i = '0;
    bus.data_i = '0;
    bus.host_en = 1'b0;
    bus.host_we = 1'b0;
    bus.host_addr = '0;
    bus.host_wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_data_o", 64'(bus.data_o), 64'd0);
    check("rst_opdone", 64'(bus.mem_opdone), 64'd0);
    check("rst_hrdata", 64'(bus.host_rdata), 64'd0);
    check("rst_hready", 64'(bus.host_ready), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    reset = 1'b0;

    // Preload a window of known words, then the four words of the back-to-back read.
    for (int i = 4; i < 64; i++) host_access(1'b1, ADDR_BW'(i), $urandom, "pre");
    for (int i = 0; i < 4; i++)  host_access(1'b1, ADDR_BW'(i), 32'd2, "pre2");

    @(negedge clk);
    bus.mem_operation = 2'b01;
    bus.addr_i = 32'd0;
    c0 = cyc;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!bus.mem_opdone && w < 30);
      check("b2b_done", 64'(bus.mem_opdone), 64'd1);
      check("b2b_data", 64'(bus.data_o), 64'd2);
      if (k == 0) check("b2b_lat", 64'(cyc - c0), 64'(RD_LAT));
      else        check("b2b_space", 64'(cyc - prev), 64'(RD_LAT + 2));
      prev = cyc;
      bus.addr_i = 32'(k + 1);
    end
    bus.mem_operation = 2'b00;
    repeat (2) @(posedge clk);

    acc_op(2'b11, 32'd12, 32'h1234, "wr12");
    host_access(1'b0, ADDR_BW'(12), '0, "hrd12");

    // Host and accelerator request in the same cycle; the accelerator must win.
    @(negedge clk);
    bus.mem_operation = 2'b01;
    bus.addr_i = 32'd5;
    bus.host_en = 1'b1;
    bus.host_we = 1'b0;
    bus.host_addr = ADDR_BW'(7);
    #1;
    check("coll_hready", 64'(bus.host_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    bus.mem_operation = 2'b00;
    #1;
    check("busy_hready", 64'(bus.host_ready), 64'd0);
    w = 0;
    while (!bus.mem_opdone && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("coll_data", 64'(bus.data_o), 64'(model[5]));
    #1;
    check("done_hready", 64'(bus.host_ready), 64'd0);
    host_access(1'b0, ADDR_BW'(7), '0, "coll_host");

    for (int n = 0; n < 60; n++) begin
      a = 32'($urandom_range(0, 63));
      d = $urandom;
      case ($urandom_range(0, 3))
        0: acc_op(2'b01, a, '0, "rnd_ard");
        1: acc_op(2'b11, a, d, "rnd_awr");
        2: host_access(1'b0, a[ADDR_BW-1:0], '0, "rnd_hrd");
        default: host_access(1'b1, a[ADDR_BW-1:0], d, "rnd_hwr");
      endcase
    end
    check("err_clean", 64'(err_o), 64'd0);

    acc_op(2'b01, 32'h400, '0, "oor_rd");
    check("oor_err", 64'(err_o), 64'(err_exp));
    acc_op(2'b11, 32'h400, 32'hdead_beef, "oor_wr");
    host_access(1'b0, ADDR_BW'(0), '0, "oor_alias");
    check("oor_sticky", 64'(err_o), 64'd1);

    // Illegal op after a reset so the error flag starts clear.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    err_exp = 1'b0;
    check("ill_pre", 64'(err_o), 64'd0);
    bus.mem_operation = 2'b10;
    bus.addr_i = 32'd9;
    bus.data_i = 32'hffff_ffff;
    @(posedge clk);
    @(negedge clk);
    bus.mem_operation = 2'b00;
    bad = 0;
    repeat (5) begin
      if (bus.mem_opdone) bad++;
      @(negedge clk);
    end
    check("ill_nodone", 64'(bad), 64'd0);
    check("ill_err", 64'(err_o), 64'd1);
    host_access(1'b0, ADDR_BW'(9), '0, "ill_mem");

    acc_op(2'b01, 32'd33, '0, "pre_rst");
    @(negedge clk);
    bus.mem_operation = 2'b01;
    bus.addr_i = 32'd20;
    @(posedge clk);
    @(negedge clk);
    bus.mem_operation = 2'b00;
    reset = 1'b1;
    bus.host_en = 1'b1;
    #1;
    check("mid_data_o", 64'(bus.data_o), 64'd0);
    check("mid_opdone", 64'(bus.mem_opdone), 64'd0);
    check("mid_hrdata", 64'(bus.host_rdata), 64'd0);
    check("mid_hready", 64'(bus.host_ready), 64'd0);
    check("mid_err", 64'(err_o), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    bus.host_en = 1'b0;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.mem_opdone) bad++;
    end
    check("mid_nodone", 64'(bad), 64'd0);
    acc_op(2'b01, 32'd20, '0, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
